// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer owning the PC
module instr_sequencer #(
    parameter int PC_W = 4,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_ready,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic [IW-1:0]   ir,
    output logic            alu_en,
    output logic            rf_we,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] opcode;

    assign opcode = ir[IW-1:IW-2];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH;
            S_FETCH:     if (imem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ALU:  state_nxt = S_EXECUTE;
                    OP_LDI:  state_nxt = S_WRITEBACK;
                    OP_JMP:  state_nxt = S_FETCH;
                    default: state_nxt = S_HALT;
                endcase
            end
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      if (start) state_nxt = S_FETCH;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state, so each one is a pure
    // function of the state register with no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            imem_req <= 1'b0;
            alu_en   <= 1'b0;
            rf_we    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == S_FETCH);
            alu_en   <= (state_nxt == S_EXECUTE);
            rf_we    <= (state_nxt == S_WRITEBACK);
            busy     <= (state_nxt == S_FETCH) || (state_nxt == S_DECODE) ||
                        (state_nxt == S_EXECUTE) || (state_nxt == S_WRITEBACK);
            halted   <= (state_nxt == S_HALT);

            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                // Jump target overrides the pc already incremented in FETCH.
                S_DECODE: if (opcode == OP_JMP) pc <= ir[PC_W-1:0];
                S_HALT:   if (start) pc <= '0;
                default: ;
            endcase
        end
    end

endmodule
